grostl_sub_bytes_seq: RTL and testbench



---
 rtl/grostl_sub_bytes_seq.sv | 78 +++++++
 tb/tb_grostl_sub_bytes_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/grostl_sub_bytes_seq.sv
// grostl_sub_bytes_seq: sequential Grostl SubBytes, LANES S-boxes swept over BYTES/LANES beats
module grostl_sbox_lut (
  input  logic [7:0] i_a,
  output logic [7:0] o_y
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign o_y = SBOX[i_a];
endmodule

module grostl_sub_bytes_seq #(
  parameter int BYTES = 64,
  parameter int LANES = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [0:BYTES-1][7:0]  din,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [0:BYTES-1][7:0]  dout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
);
  localparam int BEATS = BYTES / LANES;
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t                  r_state;
  logic [0:BYTES-1][7:0]   r_st;
  logic [0:BYTES-1][7:0]   w_rot;
  logic [0:LANES-1][7:0]   w_sub;
  logic [CW-1:0]           r_cnt;
  logic                    w_load;
  if (BYTES % LANES != 0) begin : g_chk
    $error("BYTES must be a multiple of LANES");
  end
  for (genvar i = 0; i < LANES; i++) begin : g_sbox
    grostl_sbox_lut u_sbox (.i_a(r_st[i]), .o_y(w_sub[i]));
  end
  // head bytes go through the S-boxes and re-enter at the tail
  for (genvar i = 0; i < BYTES; i++) begin : g_rot
    if (i < BYTES - LANES) begin : g_sh
      assign w_rot[i] = r_st[i+LANES];
    end else begin : g_sb
      assign w_rot[i] = w_sub[i-(BYTES-LANES)];
    end
  end
  assign in_ready  = (r_state == IDLE) | (r_state == DONE & out_ready);
  assign w_load    = in_valid & in_ready;
  assign out_valid = r_state == DONE;
  assign busy      = r_state == BUSY;
  assign dout      = r_st;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_st    <= '0;
      r_cnt   <= '0;
    end else if (w_load) begin
      r_state <= BUSY;
      r_st    <= din;
      r_cnt   <= '0;
    end else if (r_state == BUSY) begin
      r_st  <= w_rot;
      r_cnt <= r_cnt + CW'(1);
      if (r_cnt == CW'(BEATS - 1)) r_state <= DONE;
    end else if (r_state == DONE && out_ready) begin
      r_state <= IDLE;
    end
  end
endmodule

// File: tb/tb_grostl_sub_bytes_seq.sv
// tb_grostl_sub_bytes_seq: scoreboard bench over LANES = 8, 1, 64 instances of the SubBytes unit
module tb_grostl_sub_bytes_seq;
  typedef logic [0:63][7:0] blk_t;
  typedef struct { int d; blk_t v; } exp_t;
  localparam logic [0:255][7:0] SB = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  logic       clk, rst_n;
  blk_t       din;
  logic [2:0] in_valid, in_ready, out_valid, out_ready, busy;
  blk_t       dout [3];
  int         checks = 0, errors = 0, cyc = 0;
  int         bcnt [3];
  int         beats [3] = '{8, 64, 1};
  exp_t       q [$];
  int         pops [$];
  int         m_idx;

  grostl_sub_bytes_seq #(.BYTES(64), .LANES(8)) u0 (
    .clk(clk), .rst_n(rst_n), .din(din), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .dout(dout[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .busy(busy[0]));
  grostl_sub_bytes_seq #(.BYTES(64), .LANES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .din(din), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .dout(dout[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .busy(busy[1]));
  grostl_sub_bytes_seq #(.BYTES(64), .LANES(64)) u2 (
    .clk(clk), .rst_n(rst_n), .din(din), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .dout(dout[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]), .busy(busy[2]));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc++;
  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic blk_t sub(input blk_t x);
    blk_t r;
    for (int i = 0; i < 64; i++) r[i] = SB[x[i]];
    return r;
  endfunction

  function automatic blk_t rnd();
    blk_t r;
    for (int i = 0; i < 64; i++) r[i] = 8'($urandom);
    return r;
  endfunction

  // monitor: pops the scoreboard on every output handshake and checks busy length
  always @(negedge clk) begin
    if (!rst_n) bcnt = '{0, 0, 0};
    else for (int d = 0; d < 3; d++) begin
      if (busy[d]) bcnt[d]++;
      if (out_valid[d] && out_ready[d]) begin
        chk($sformatf("in_ready_done%0d", d), 512'(in_ready[d]), 512'd1);
        m_idx = -1;
        foreach (q[j]) if (m_idx < 0 && q[j].d == d) m_idx = j;
        checks++;
        if (m_idx < 0) begin
          errors++;
          $display("FAIL unexpected_out%0d got=%h want=none", d, dout[d]);
        end else begin
          chk($sformatf("dout%0d", d), dout[d], q[m_idx].v);
          chk($sformatf("busy_len%0d", d), 512'(bcnt[d]), 512'(beats[d]));
          q.delete(m_idx);
          if (d == 0) pops.push_back(cyc);
        end
        bcnt[d] = 0;
      end
    end
  end

  task automatic send(input int d, input blk_t x, input blk_t e, input bit keep);
    int t = 0;
    din = x;
    in_valid[d] = 1;
    @(negedge clk);
    while (!in_ready[d] && t < 200) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!in_ready[d]) begin
      errors++;
      $display("FAIL send_timeout%0d got=in_ready 0 want=1", d);
    end else q.push_back('{d, e});
    @(posedge clk);
    #1 in_valid[d] = keep;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 400) begin
      @(posedge clk);
      t++;
    end
    chk("drain", 512'(q.size()), 512'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    blk_t x, e;
    int t, viol;
    rst_n = 0;
    in_valid = '0;
    out_ready = '1;
    din = '0;
    #2;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_out_valid%0d", d), 512'(out_valid[d]), 512'd0);
      chk($sformatf("rst_busy%0d", d), 512'(busy[d]), 512'd0);
      chk($sformatf("rst_in_ready%0d", d), 512'(in_ready[d]), 512'd1);
      chk($sformatf("rst_dout%0d", d), dout[d], 512'd0);
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 64; i++) e[i] = 8'h63;
    send(0, '0, e, 0);
    x = '0;
    x[1] = 8'h01;
    x[2] = 8'h53;
    e[1] = 8'h7c;
    e[2] = 8'hed;
    send(0, x, e, 0);
    drain();
    for (int d = 0; d < 3; d++) repeat (2) begin
      x = rnd();
      send(d, x, sub(x), 0);
      drain();
    end
    x = rnd();
    send(0, x, sub(x), 0);
    repeat (4) begin
      din = rnd();
      in_valid[0] = ~in_valid[0];
      @(posedge clk);
      #1;
    end
    in_valid[0] = 0;
    drain();
    out_ready[0] = 0;
    x = rnd();
    send(0, x, sub(x), 0);
    t = 0;
    @(negedge clk);
    while (!out_valid[0] && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (20) begin
      chk("bp_out_valid", 512'(out_valid[0]), 512'd1);
      chk("bp_dout", dout[0], sub(x));
      chk("bp_in_ready", 512'(in_ready[0]), 512'd0);
      chk("bp_busy", 512'(busy[0]), 512'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready[0] = 1;
    @(posedge clk);
    #1 chk("bp_release", 512'(out_valid[0]), 512'd0);
    drain();
    pops.delete();
    for (int b = 0; b < 4; b++) begin
      x = rnd();
      send(0, x, sub(x), b < 3);
    end
    drain();
    chk("stream_count", 512'(pops.size()), 512'd4);
    if (pops.size() == 4)
      for (int j = 1; j < 4; j++) chk("stream_gap", 512'(pops[j] - pops[j-1]), 512'd9);
    x = rnd();
    send(0, x, sub(x), 0);
    repeat (3) @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("abort_out_valid", 512'(out_valid[0]), 512'd0);
    chk("abort_busy", 512'(busy[0]), 512'd0);
    chk("abort_in_ready", 512'(in_ready[0]), 512'd1);
    chk("abort_dout", dout[0], 512'd0);
    q.delete();
    @(posedge clk);
    #2 rst_n = 1;
    viol = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid[0]) viol++;
    end
    chk("abort_no_valid", 512'(viol), 512'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
